altr_hps_deglitch: RTL and testbench

Single-bit input conditioner for the HPS standard macro library.
- Synchronizes an asynchronous level input (e.g. pad, wake, or status lines that are then decoded by downstream altr_hps gate macros).
- Rejects glitches shorter than a programmable number of clk cycles.
- Produces a clean filtered level plus single-cycle rise and fall event pulses.
- Sits between the asynchronous source and the synchronous control logic.

---
 rtl/altr_hps_deglitch.sv | 146 ++++++++++++++
 tb/tb_altr_hps_deglitch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altr_hps_deglitch.sv
// altr_hps_deglitch
// Single-bit input conditioner: multi-flop synchronizer followed by a
// qualification FSM that only accepts a new level after it has held for
// FILTER_CYCLES consecutive synchronized cycles. Emits registered one-cycle
// rise/fall pulses on every accepted transition.
//
// Optional feature macro: ALTR_HPS_DEGLITCH_STICKY_EN
//   When defined, adds evt_clr/evt_sticky: a latched "any transition" flag.
//   evt_clr clears it synchronously, and a pulse in the same cycle wins.

module altr_hps_deglitch #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter int   CNT_WIDTH     = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise_pls,
    output logic fall_pls,
    output logic busy
`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
    ,
    input  logic evt_clr,
    output logic evt_sticky
`endif
);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_QUAL   = 1'b1;

    // A filter of one cycle needs no QUAL state: accept directly from STABLE.
    localparam bit                   C_BYPASS   = (FILTER_CYCLES == 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_d_s;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_dout;
    logic                 w_dout_next;
    logic                 w_update;
    logic                 r_rise;
    logic                 r_fall;

    // Synchronizer chain: plain flop-to-flop, nothing between stages.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous input.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_sync[gi] <= RESET_VAL;
                    else     r_sync[gi] <= din;
                end
            end else begin : g_next
                // Later stages only re-register the previous stage.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_sync[gi] <= RESET_VAL;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_d_s = r_sync[SYNC_STAGES-1];

    // Qualification next-state: any return of d_s to dout restarts from scratch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dout_next  = r_dout;
        w_update     = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_d_s != r_dout) begin
                    if (C_BYPASS) begin
                        w_dout_next = w_d_s;
                        w_update    = 1'b1;
                    end else begin
                        w_state_next = ST_QUAL;
                        w_cnt_next   = C_CNT_ONE;
                    end
                end
            end
            ST_QUAL: begin
                if (w_d_s == r_dout) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_dout_next  = w_d_s;
                    w_update     = 1'b1;
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM, filtered level and event pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_dout  <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dout  <= w_dout_next;
            r_rise  <= w_update & w_d_s;
            r_fall  <= w_update & ~w_d_s;
        end
    end

    assign dout     = r_dout;
    assign rise_pls = r_rise;
    assign fall_pls = r_fall;
    assign busy     = (r_state == ST_QUAL);

`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
    logic r_sticky;

    // Sticky transition flag: a pulse sets it and overrides a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_sticky <= 1'b0;
        else if (r_rise || r_fall)   r_sticky <= 1'b1;
        else if (evt_clr)            r_sticky <= 1'b0;
    end

    assign evt_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_altr_hps_deglitch.sv
// Directed testbench for altr_hps_deglitch with default parameters
// (SYNC_STAGES=2, FILTER_CYCLES=4, RESET_VAL=0). Inputs change and outputs
// are sampled on the falling clock edge; "k" counts rising edges since the
// input change, so a stable change shows on dout at k = 2 + 4 = 6, with busy
// high while the FSM is in QUAL (k = 3..5).

module tb_altr_hps_deglitch;

    logic clk;
    logic rst;
    logic din;
    logic dout;
    logic rise_pls;
    logic fall_pls;
    logic busy;
`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
    logic evt_clr;
    logic evt_sticky;
`endif

    int n_checks;
    int n_errors;

    altr_hps_deglitch #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .CNT_WIDTH     (8),
        .RESET_VAL     (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .dout     (dout),
        .rise_pls (rise_pls),
        .fall_pls (fall_pls),
        .busy     (busy)
`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
        ,
        .evt_clr    (evt_clr),
        .evt_sticky (evt_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        int falls;
        rst = 1'b1;
        din = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise_pls, fall_pls, busy} !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_hold k=%0d got dout/rise/fall/busy=%b expected 0000", k,
                         {dout, rise_pls, fall_pls, busy});
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise_pls, fall_pls, busy} !== {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)}) begin
                n_errors++;
                $display("FAIL reset_release k=%0d got dout/rise/fall/busy=%b expected %b", k,
                         {dout, rise_pls, fall_pls, busy},
                         {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)});
            end
        end
        din   = 1'b0;
        falls = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (fall_pls) falls++;
        end
        n_checks++;
        if (falls !== 1 || dout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_settle got falls=%0d dout=%b expected falls=1 dout=0", falls, dout);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_edge();
        int busy_cnt;
        busy_cnt = 0;
        din = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            n_checks++;
            if ({dout, rise_pls, fall_pls, busy} !== {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)}) begin
                n_errors++;
                $display("FAIL clean_rise k=%0d got dout/rise/fall/busy=%b expected %b", k,
                         {dout, rise_pls, fall_pls, busy},
                         {k >= 6, k == 6, 1'b0, (k >= 3 && k <= 5)});
            end
        end
        n_checks++;
        if (busy_cnt !== 3) begin
            n_errors++;
            $display("FAIL clean_busy_len got %0d expected 3", busy_cnt);
        end
        din = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dout, rise_pls, fall_pls, busy} !== {k < 6, 1'b0, k == 6, (k >= 3 && k <= 5)}) begin
                n_errors++;
                $display("FAIL clean_fall k=%0d got dout/rise/fall/busy=%b expected %b", k,
                         {dout, rise_pls, fall_pls, busy},
                         {k < 6, 1'b0, k == 6, (k >= 3 && k <= 5)});
            end
        end
        $display("test_clean_edge done");
    endtask

    task automatic test_glitch();
        int busy_cnt;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            din = (k <= 3);
            @(negedge clk);
            if (busy) busy_cnt++;
            n_checks++;
            if ({dout, rise_pls, fall_pls} !== 3'b000) begin
                n_errors++;
                $display("FAIL glitch k=%0d got dout/rise/fall=%b expected 000", k,
                         {dout, rise_pls, fall_pls});
            end
        end
        n_checks++;
        if (busy_cnt !== 3) begin
            n_errors++;
            $display("FAIL glitch_busy_len got %0d expected 3", busy_cnt);
        end
        $display("test_glitch done");
    endtask

    task automatic test_chatter();
        logic [7:0] pat;
        int         rises;
        pat   = 8'b1111_0111;   // bit k-1 applied before edge k: 1,1,1,0,1,1,1,1
        rises = 0;
        for (int k = 1; k <= 13; k++) begin
            din = (k <= 8) ? pat[k-1] : 1'b1;
            @(negedge clk);
            if (rise_pls) rises++;
            n_checks++;
            if ({dout, rise_pls, fall_pls, busy} !==
                {k >= 10, k == 10, 1'b0, ((k >= 3 && k <= 5) || (k >= 7 && k <= 9))}) begin
                n_errors++;
                $display("FAIL chatter k=%0d got dout/rise/fall/busy=%b expected %b", k,
                         {dout, rise_pls, fall_pls, busy},
                         {k >= 10, k == 10, 1'b0, ((k >= 3 && k <= 5) || (k >= 7 && k <= 9))});
            end
        end
        n_checks++;
        if (rises !== 1) begin
            n_errors++;
            $display("FAIL chatter_rise_count got %0d expected 1", rises);
        end
        din = 1'b0;
        repeat (9) @(negedge clk);
        $display("test_chatter done");
    endtask

    task automatic test_reset_mid_qual();
        int pulses;
        din = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midq_in_qual got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dout, rise_pls, fall_pls, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midq_async got dout/rise/fall/busy=%b expected 0000",
                     {dout, rise_pls, fall_pls, busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rise_pls || fall_pls) pulses++;
            n_checks++;
            if ({dout, busy} !== {k >= 6, (k >= 3 && k <= 5)}) begin
                n_errors++;
                $display("FAIL midq_release k=%0d got dout/busy=%b expected %b", k,
                         {dout, busy}, {k >= 6, (k >= 3 && k <= 5)});
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_errors++;
            $display("FAIL midq_pulse_count got %0d expected 1", pulses);
        end
        din = 1'b0;
        repeat (9) @(negedge clk);
        $display("test_reset_mid_qual done");
    endtask

`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
    task automatic test_sticky();
        n_checks++;
        if (evt_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL sticky_pre_clear got %b expected 0", evt_sticky);
        end
        din = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (evt_sticky !== (k >= 7)) begin
                n_errors++;
                $display("FAIL sticky_set k=%0d got %b expected %b", k, evt_sticky, (k >= 7));
            end
        end
        evt_clr = 1'b1;
        @(negedge clk);
        evt_clr = 1'b0;
        n_checks++;
        if (evt_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL sticky_clear got %b expected 0", evt_sticky);
        end
        // Hold clear through the whole fall so it coincides with fall_pls.
        evt_clr = 1'b1;
        din     = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({fall_pls, evt_sticky} !== {k == 6, k >= 7}) begin
                n_errors++;
                $display("FAIL sticky_set_wins k=%0d got fall/sticky=%b expected %b", k,
                         {fall_pls, evt_sticky}, {k == 6, k >= 7});
            end
            if (k == 7) evt_clr = 1'b0;
        end
        n_checks++;
        if (evt_sticky !== 1'b1) begin
            n_errors++;
            $display("FAIL sticky_hold got %b expected 1", evt_sticky);
        end
        $display("test_sticky done");
    endtask
`endif

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        din      = 1'b0;
        n_checks = 0;
        n_errors = 0;
`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
        evt_clr  = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_clean_edge();
        test_glitch();
        test_chatter();
        test_reset_mid_qual();
`ifdef ALTR_HPS_DEGLITCH_STICKY_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
